// File: rtl/lcd_pkg.sv
// Shared types and constants for the 8080-style ST7789 panel driver.
// Optional build macro: LCD_DROP_CNT_EN (adds a dropped-pixel counter to lcd_driver).
package lcd_pkg;

    typedef enum logic [2:0] {
        StRstLow,
        StRstWait,
        StInit,
        StInitDelay,
        StWindow,
        StIdle,
        StPixHi,
        StPixLo
    } state_e;

    localparam logic [7:0] OpSwreset = 8'h01;
    localparam logic [7:0] OpSlpout  = 8'h11;
    localparam logic [7:0] OpColmod  = 8'h3A;
    localparam logic [7:0] OpMadctl  = 8'h36;
    localparam logic [7:0] OpInvon   = 8'h21;
    localparam logic [7:0] OpDispon  = 8'h29;
    localparam logic [7:0] OpCaset   = 8'h2A;
    localparam logic [7:0] OpRaset   = 8'h2B;
    localparam logic [7:0] OpRamwr   = 8'h2C;

    localparam int unsigned PanelW = 320;
    localparam int unsigned PanelH = 240;

    localparam logic [15:0] ColEnd = 16'(PanelW - 1);
    localparam logic [15:0] RowEnd = 16'(PanelH - 1);

    localparam int unsigned InitEntries = 8;
    localparam int unsigned WinBytes    = 11;

    // One init-ROM / window-table entry: {is_data, delay, value}.
    typedef struct packed {
        logic       is_data;
        logic       delay;
        logic [7:0] value;
    } wr_entry_t;

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one 8080 byte write: bus held for the whole byte, WR low then high.
// done_o marks the last clock of a byte so the next one can start immediately.
module lcd_byte_writer #(
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       cmd_data_i,
    output logic       done_o,
    output logic       write_edge_o,
    output logic [7:0] dout_o,
    output logic       cmd_data_o
);

    localparam int unsigned WrW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    logic [WrW-1:0] cnt_q;
    logic           active_q;
    logic           we_q;
    logic [7:0]     dout_q;
    logic           cd_q;
    logic           phase_end;

    assign phase_end    = (cnt_q == WrW'(WR_CYCLES - 1));
    assign done_o       = active_q && we_q && phase_end;
    assign write_edge_o = we_q;
    assign dout_o       = dout_q;
    assign cmd_data_o   = cd_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            we_q     <= 1'b1;
            dout_q   <= 8'h00;
            cd_q     <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= '0;
            active_q <= 1'b1;
            we_q     <= 1'b0;
            dout_q   <= data_i;
            cd_q     <= cmd_data_i;
        end else if (active_q) begin
            if (phase_end) begin
                cnt_q <= '0;
                if (!we_q) begin
                    we_q <= 1'b1;
                end else begin
                    active_q <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_driver.sv
// Power-up, window setup and RGB565 pixel streaming for an ST7789-class 320x240 panel.
// Optional build macro: LCD_DROP_CNT_EN adds dropped_cnt, a saturating dropped-pixel count.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 250000,
    parameter int unsigned DELAY_CYCLES = 3000000,
    parameter int unsigned WR_CYCLES    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_clk,
    input  logic [15:0] pix_data,
    input  logic        reset_cursor,
    output logic        busy,
    output logic        nreset,
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout
`ifdef LCD_DROP_CNT_EN
    ,
    output logic [15:0] dropped_cnt
`endif
);

    localparam int unsigned MaxCycles = (RESET_CYCLES > DELAY_CYCLES) ? RESET_CYCLES : DELAY_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    function automatic wr_entry_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{is_data: 1'b0, delay: 1'b1, value: OpSwreset};
            3'd1:    return '{is_data: 1'b0, delay: 1'b1, value: OpSlpout};
            3'd2:    return '{is_data: 1'b0, delay: 1'b0, value: OpColmod};
            3'd3:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h55};
            3'd4:    return '{is_data: 1'b0, delay: 1'b0, value: OpMadctl};
            3'd5:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h60};
            3'd6:    return '{is_data: 1'b0, delay: 1'b0, value: OpInvon};
            default: return '{is_data: 1'b0, delay: 1'b0, value: OpDispon};
        endcase
    endfunction

    function automatic wr_entry_t win_tab(input logic [3:0] idx);
        case (idx)
            4'd0:    return '{is_data: 1'b0, delay: 1'b0, value: OpCaset};
            4'd1:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h00};
            4'd2:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h00};
            4'd3:    return '{is_data: 1'b1, delay: 1'b0, value: ColEnd[15:8]};
            4'd4:    return '{is_data: 1'b1, delay: 1'b0, value: ColEnd[7:0]};
            4'd5:    return '{is_data: 1'b0, delay: 1'b0, value: OpRaset};
            4'd6:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h00};
            4'd7:    return '{is_data: 1'b1, delay: 1'b0, value: 8'h00};
            4'd8:    return '{is_data: 1'b1, delay: 1'b0, value: RowEnd[15:8]};
            4'd9:    return '{is_data: 1'b1, delay: 1'b0, value: RowEnd[7:0]};
            4'd10:   return '{is_data: 1'b0, delay: 1'b0, value: OpRamwr};
            default: return '0;
        endcase
    endfunction

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      rom_idx_q;
    logic [3:0]      win_idx_q;
    logic            pending_q;
    logic            busy_q;
    logic            nreset_q;
    logic [7:0]      pix_lo_q;

    logic      wr_start;
    logic      wr_done;
    wr_entry_t wr_entry;
    wr_entry_t cur_entry;
    wr_entry_t init_next;
    logic      rst_end;
    logic      dly_end;
    logic      rom_last;
    logic      win_last;
    logic      pend_now;

    assign cur_entry = init_rom(rom_idx_q);
    assign rom_last  = (rom_idx_q == 3'(InitEntries - 1));
    assign win_last  = (win_idx_q == 4'(WinBytes));
    assign init_next = rom_last ? win_tab(4'd0) : init_rom(rom_idx_q + 3'd1);
    assign rst_end   = (cnt_q == CntW'(RESET_CYCLES - 1));
    assign dly_end   = (cnt_q == CntW'(DELAY_CYCLES - 1));
    assign pend_now  = pending_q | reset_cursor;
    assign busy      = busy_q;
    assign nreset    = nreset_q;

    // Next byte is launched on the same edge the previous one finishes, keeping bytes gapless.
    always_comb begin
        wr_start = 1'b0;
        wr_entry = '0;
        unique case (state_q)
            StRstWait: if (rst_end) begin
                wr_start = 1'b1;
                wr_entry = init_rom(3'd0);
            end
            StInit: if (wr_done && !cur_entry.delay) begin
                wr_start = 1'b1;
                wr_entry = init_next;
            end
            StInitDelay: if (dly_end) begin
                wr_start = 1'b1;
                wr_entry = init_next;
            end
            StWindow: if (wr_done && (!win_last || pend_now)) begin
                wr_start = 1'b1;
                wr_entry = win_last ? win_tab(4'd0) : win_tab(win_idx_q);
            end
            StIdle: if (reset_cursor) begin
                wr_start = 1'b1;
                wr_entry = win_tab(4'd0);
            end else if (pix_clk) begin
                wr_start = 1'b1;
                wr_entry = '{is_data: 1'b1, delay: 1'b0, value: pix_data[15:8]};
            end
            StPixHi: if (wr_done) begin
                wr_start = 1'b1;
                wr_entry = '{is_data: 1'b1, delay: 1'b0, value: pix_lo_q};
            end
            StPixLo: if (wr_done && pend_now) begin
                wr_start = 1'b1;
                wr_entry = win_tab(4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StRstLow;
            cnt_q     <= '0;
            rom_idx_q <= '0;
            win_idx_q <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            nreset_q  <= 1'b0;
            pix_lo_q  <= 8'h00;
        end else begin
            unique case (state_q)
                StRstLow: if (rst_end) begin
                    cnt_q    <= '0;
                    nreset_q <= 1'b1;
                    state_q  <= StRstWait;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                StRstWait: if (rst_end) begin
                    cnt_q     <= '0;
                    rom_idx_q <= '0;
                    state_q   <= StInit;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                StInit: if (wr_done) begin
                    if (cur_entry.delay) begin
                        state_q <= StInitDelay;
                    end else if (rom_last) begin
                        state_q   <= StWindow;
                        win_idx_q <= 4'd1;
                    end else begin
                        rom_idx_q <= rom_idx_q + 3'd1;
                    end
                end
                StInitDelay: if (dly_end) begin
                    cnt_q <= '0;
                    if (rom_last) begin
                        state_q   <= StWindow;
                        win_idx_q <= 4'd1;
                    end else begin
                        rom_idx_q <= rom_idx_q + 3'd1;
                        state_q   <= StInit;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                StWindow: if (wr_done && win_last) begin
                    pending_q <= 1'b0;
                    if (pend_now) begin
                        win_idx_q <= 4'd1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    if (wr_done) begin
                        win_idx_q <= win_idx_q + 4'd1;
                    end
                    pending_q <= pend_now;
                end
                StIdle: if (reset_cursor) begin
                    state_q   <= StWindow;
                    win_idx_q <= 4'd1;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b1;
                end else if (pix_clk) begin
                    pix_lo_q <= pix_data[7:0];
                    state_q  <= StPixHi;
                    busy_q   <= 1'b1;
                end
                StPixHi: begin
                    pending_q <= pend_now;
                    if (wr_done) begin
                        state_q <= StPixLo;
                    end
                end
                StPixLo: if (wr_done) begin
                    pending_q <= 1'b0;
                    if (pend_now) begin
                        state_q   <= StWindow;
                        win_idx_q <= 4'd1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    pending_q <= pend_now;
                end
                default: state_q <= StRstLow;
            endcase
        end
    end

`ifdef LCD_DROP_CNT_EN
    logic [15:0] drop_q;
    logic        cur_acc;
    logic        pix_drop;

    assign cur_acc     = reset_cursor && (state_q inside {StIdle, StWindow, StPixHi, StPixLo});
    assign pix_drop    = pix_clk && (busy_q || reset_cursor);
    assign dropped_cnt = drop_q;

    // A cursor accept clears first; a pixel it displaces in the same cycle still counts.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            drop_q <= 16'h0000;
        end else if (cur_acc) begin
            drop_q <= pix_drop ? 16'h0001 : 16'h0000;
        end else if (pix_drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'h0001;
        end
    end
`endif

    lcd_byte_writer #(
        .WR_CYCLES(WR_CYCLES)
    ) u_writer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (wr_start),
        .data_i      (wr_entry.value),
        .cmd_data_i  (wr_entry.is_data),
        .done_o      (wr_done),
        .write_edge_o(write_edge),
        .dout_o      (dout),
        .cmd_data_o  (cmd_data)
    );

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver: scoreboard of {cmd_data, dout} bytes captured on rising WR.
module tb_lcd_driver;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        pix_clk = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        reset_cursor = 1'b0;
    logic        busy;
    logic        nreset;
    logic        cmd_data;
    logic        write_edge;
    logic [7:0]  dout;
`ifdef LCD_DROP_CNT_EN
    logic [15:0] dropped_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    int         rise_cyc[$];
    logic       we_prev = 1'b1;
    logic [8:0] exp_v;

    // {is_data, byte}: full power-up stream; the last 11 entries are the window sequence.
    logic [8:0] init_seq [19] = '{
        9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h160, 9'h021, 9'h029,
        9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
        9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C
    };

    lcd_driver #(
        .RESET_CYCLES(4),
        .DELAY_CYCLES(8),
        .WR_CYCLES   (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pix_clk     (pix_clk),
        .pix_data    (pix_data),
        .reset_cursor(reset_cursor),
        .busy        (busy),
        .nreset      (nreset),
        .cmd_data    (cmd_data),
        .write_edge  (write_edge),
        .dout        (dout)
`ifdef LCD_DROP_CNT_EN
        ,
        .dropped_cnt (dropped_cnt)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (!we_prev && write_edge) begin
            rise_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL byte_extra: observed %h expected none", {cmd_data, dout});
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                assert ({cmd_data, dout} === exp_v) else begin
                    errors++;
                    $error("FAIL byte: observed %h expected %h", {cmd_data, dout}, exp_v);
                end
            end
        end
        we_prev = write_edge;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_window();
        for (int i = 8; i < 19; i++) exp_q.push_back(init_seq[i]);
    endtask

    task automatic wait_idle(output int fall);
        fall = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (busy === 1'b0) begin
                fall = cyc;
                break;
            end
        end
        chk("idle_reached", 32'(fall != -1), 32'd1);
    endtask

    task automatic powerup();
        int n;
        int base;
        int fall;
        for (int i = 0; i < 19; i++) exp_q.push_back(init_seq[i]);
        base = rise_cyc.size();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (nreset === 1'b1) break;
            n++;
        end
        chk("nreset_low_clocks", 32'(n), 32'd4);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (write_edge === 1'b0) break;
            n++;
            @(negedge clk_i);
        end
        chk("nreset_high_clocks", 32'(n), 32'd4);
        wait_idle(fall);
        chk("init_queue_empty", 32'(exp_q.size()), 32'd0);
        if (rise_cyc.size() >= base + 4) begin
            chk("gap_after_01", 32'(rise_cyc[base+1] - rise_cyc[base]), 32'd10);
            chk("gap_after_11", 32'(rise_cyc[base+2] - rise_cyc[base+1]), 32'd10);
            chk("gap_plain", 32'(rise_cyc[base+3] - rise_cyc[base+2]), 32'd2);
        end else begin
            chk("init_byte_count", 32'(rise_cyc.size() - base), 32'd19);
        end
    endtask

    initial begin
        int acc;
        int fall;

        // Reset values
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_nreset", 32'(nreset), 32'd0);
        chk("rst_write_edge", 32'(write_edge), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cmd_data", 32'(cmd_data), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        powerup();

        // Pixel F81F, with a second strobe one clock later that must be dropped
        @(posedge clk_i);
        #1 pix_data = 16'hF81F;
        pix_clk = 1'b1;
        exp_q.push_back(9'h1F8);
        exp_q.push_back(9'h11F);
        @(posedge clk_i);
        #1 acc = cyc;
        pix_data = 16'h07E0;
        @(negedge clk_i);
        chk("busy_after_accept", 32'(busy), 32'd1);
        @(posedge clk_i);
        #1 pix_clk = 1'b0;
        wait_idle(fall);
        chk("pix_busy_clocks", 32'(fall - acc), 32'd4);
        repeat (4) @(negedge clk_i);
        chk("pix_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef LCD_DROP_CNT_EN
        chk("dropped_cnt", 32'(dropped_cnt), 32'd1);
`endif

        // Cursor request during PIX_HI: pixel finishes, then window
        @(posedge clk_i);
        #1 pix_data = 16'h1234;
        pix_clk = 1'b1;
        exp_q.push_back(9'h112);
        exp_q.push_back(9'h134);
        push_window();
        @(posedge clk_i);
        #1 acc = cyc;
        pix_clk = 1'b0;
        reset_cursor = 1'b1;
        @(posedge clk_i);
        #1 reset_cursor = 1'b0;
        wait_idle(fall);
        chk("pending_busy_clocks", 32'(fall - acc), 32'd26);
        repeat (4) @(negedge clk_i);
        chk("pending_queue_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous strobes: cursor wins
        @(posedge clk_i);
        #1 pix_data = 16'hABCD;
        pix_clk = 1'b1;
        reset_cursor = 1'b1;
        push_window();
        @(posedge clk_i);
        #1 acc = cyc;
        pix_clk = 1'b0;
        reset_cursor = 1'b0;
        wait_idle(fall);
        chk("window_busy_clocks", 32'(fall - acc), 32'd22);
        repeat (4) @(negedge clk_i);
        chk("simul_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a window sequence, after its third byte is latched
        @(posedge clk_i);
        #1 reset_cursor = 1'b1;
        exp_q.push_back(9'h02A);
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        @(posedge clk_i);
        #1 reset_cursor = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_nreset", 32'(nreset), 32'd0);
        chk("midrst_write_edge", 32'(write_edge), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk_i);

        powerup();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
